pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
Parametrised pipeline register for the ARM core. It generalises the fixed per-stage pc registers into a chain of DEPTH register stages with a configurable payload width.
- Each stage carries a valid bit and moves data with a valid/ready handshake.
- Supports freeze (hazard stall), flush (branch squash), occupancy reporting and saturating stall/bubble counters.
- Sits between any two pipeline stages (IF→ID, ID→EX, EX→MEM) and replaces the single-field registers there.

Parameters:
DATA_W, 32, payload width in bits (pc plus any control/instruction fields packed by the caller)
DEPTH, 1, number of register stages; legal range 1..8
CNT_W, 16, width of the stall and bubble counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream presents in_data
in_ready  out  1  chain accepts in_data this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  last stage holds valid payload
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  DATA_W  payload of last stage
freeze  in  1  hold every stage; no movement, no accept
flush  in  1  squash all stages
occupancy  out  $clog2(DEPTH+1)  number of valid stages
stall_cnt  out  CNT_W  cycles with out_valid=1 and (out_ready=0 or freeze=1)
bubble_cnt  out  CNT_W  cycles with out_ready=1, freeze=0, out_valid=0

Behaviour:
- State per stage i (0=input side, DEPTH-1=output side): v[i], d[i].
- Reset (rst=1 at edge): all v=0, all d=0, stall_cnt=0, bubble_cnt=0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (when freeze=0 and flush=0).
  - rst overrides flush, freeze and any transfer in the same cycle, including mid-stream.
- Ready propagation, combinational:
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - With freeze=1 or flush=1, all r[i] are forced to 0.
- in_ready = r[0]. This is a combinational path from out_ready; it is accepted, and no skid buffer is used.
- Stage update when flush=0, freeze=0: for each i with r[i]=1:
  - v[i] <= source valid, where source is in_valid for i=0 and v[i-1] otherwise.
  - d[i] <= source data when source valid=1; otherwise d[i] holds.
  - Stages with r[i]=0 hold both v and d.
- Flush (flush=1, rst=0): all v <= 0 and all d <= 0 next edge.
  - Flush has priority over freeze.
  - in_data is not accepted that cycle (in_ready=0).
  - out_valid in the flush cycle still reflects the pre-flush state, but no transfer occurs because out_ready is ignored when flush=1.
- Freeze (freeze=1, flush=0): all v and d hold. out_valid and out_data remain visible, but no handshake completes.
- Outputs:
  - out_valid = v[DEPTH-1], out_data = d[DEPTH-1], both direct from registers.
  - occupancy = popcount(v), registered-state based.
- Latency: with out_ready=1 continuously, an accepted word appears on out_data exactly DEPTH cycles after acceptance. Throughput is 1 word/cycle.
- Backpressure: with out_ready=0 and no freeze/flush, bubbles compress. The chain fills until all DEPTH stages are valid, then in_ready=0. Data order is never altered and no word is dropped or duplicated.
- Simultaneous accept and emit on a full chain with out_ready=1: a new word enters and the oldest leaves in the same cycle; occupancy is unchanged.
- Counters:
  - Evaluated each non-reset cycle.
  - stall_cnt increments on (out_valid & (!out_ready | freeze)) & !flush.
  - bubble_cnt increments on out_ready & !freeze & !flush & !out_valid.
  - Both saturate at 2^CNT_W-1 and do not wrap. They are cleared only by rst; flush does not clear them.
- DEPTH outside 1..8: elaboration error.

Test Plan:
1. Reset, DEPTH=3: assert rst 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, occupancy=0, counters 0, in_ready=1 after release.
2. Streaming, DEPTH=3, out_ready=1: push 0x100,0x104,0x108 on consecutive cycles → out_data shows 0x100 exactly 3 cycles after its accept, then 0x104, 0x108 back-to-back; occupancy peaks at 3; bubble_cnt=3 counted over the 3 fill cycles.
3. Backpressure, DEPTH=3: out_ready=0, push 5 words → only 3 accepted (in_ready=0 after third), occupancy=3. Then raise out_ready → words emerge in order 1,2,3 and the 4th is accepted the same cycle the 1st leaves; stall_cnt counts the held cycles.
4. Freeze: full chain, freeze=1 for 4 cycles with out_ready=1 → no change to out_data/occupancy, in_ready=0, stall_cnt +4.
5. Flush with simultaneous freeze and in_valid: chain holds 2 words; assert flush=1, freeze=1, in_valid=1, in_data=0xDEAD → next cycle occupancy=0, out_valid=0, out_data=0, 0xDEAD never emitted, counters unchanged that cycle.
6. Saturation, CNT_W=4: out_ready=1, no input for 20 cycles → bubble_cnt reaches 15 and stays at 15; a subsequent rst returns it to 0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with freeze, flush, occupancy and saturating stall/bubble counters.
// Latency is DEPTH cycles at one word per cycle; ready ripples combinationally from out_ready with no skid buffer, so bubbles compress under backpressure.
module pipe_reg_chain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       freeze,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("pipe_reg_chain: DEPTH must be within 1..8");
        end
    endgenerate

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic [DEPTH-1:0]  rdy_chain;
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_d [DEPTH];
    logic              hold;
    logic [CNT_W-1:0]  stall_q, stall_d, bubble_q, bubble_d;
    logic [OCC_W-1:0]  occ;

    assign hold = freeze | flush;

    // A stage can take a word if it is empty or everything downstream of it moves.
    always_comb begin
        logic r;
        r = out_ready;
        rdy_chain = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            r = ~v_q[i] | r;
            rdy_chain[i] = r;
        end
    end

    assign rdy = hold ? '0 : rdy_chain;

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) d_d[i] = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = src_v[i];
                    if (src_v[i]) d_d[i] = src_d[i];
                end
            end
        end
    end

    // Counters saturate at all-ones; only rst clears them.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (v_q[DEPTH-1] && (!out_ready || freeze) && !flush && !(&stall_q))
            stall_d = stall_q + CNT_W'(1);
        if (out_ready && !freeze && !flush && !v_q[DEPTH-1] && !(&bubble_q))
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(v_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            v_q      <= v_d;
            d_q      <= d_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign in_ready   = rdy[0];
    assign out_valid  = v_q[DEPTH-1];
    assign out_data   = d_q[DEPTH-1];
    assign occupancy  = occ;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (DEPTH=3, CNT_W=4): directed scenarios plus random traffic,
// checked against an in-order word queue that is filled on accept and drained on emit.
module tb_pipe_reg_chain;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 4;
    localparam int OCC_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready, freeze, flush;
    logic [DATA_W-1:0] in_data, out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    pipe_reg_chain #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .freeze    (freeze),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] dat;
        int                acc;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    bit  mon_en = 0, lat_chk = 0, exp_acc = 0, zeroed = 0, exp_rdy = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0; out_ready = 1'b1; freeze = 1'b0; flush = 1'b0;
        for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) tick();
        chk(name, sb.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: occupancy and ready follow from the number of words in flight;
    // the head of the scoreboard must be what the last stage presents.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rdy = !freeze && !flush && (out_ready || sb.size() < DEPTH);
            chk("occupancy", occupancy, sb.size());
            chk("in_ready", in_ready, exp_rdy);
            if (sb.size() == 0) begin
                chk("out_valid_empty", out_valid, 0);
                if (zeroed) chk("out_data_zero", out_data, 0);
            end else begin
                if (sb.size() == DEPTH) chk("out_valid_full", out_valid, 1);
                if (out_valid) chk("out_data_order", out_data, sb[0].dat);
            end
            if (rst || flush) begin
                sb.delete();
                exp_acc = 0;
                zeroed  = 1;
            end else begin
                if (out_valid && out_ready && !freeze && sb.size() > 0) begin
                    if (lat_chk) chk("latency", cyc - sb[0].acc, DEPTH);
                    else         chk("latency_min", (cyc - sb[0].acc) >= DEPTH, 1);
                    void'(sb.pop_front());
                end
                exp_acc = in_valid && exp_rdy;
            end
        end
    end

    // Scoreboard push: record each accepted word once the handshake is known.
    always @(negedge clk) begin
        if (mon_en) begin
            #1;
            if (exp_acc) begin
                sb.push_back('{dat: in_data, acc: cyc});
                zeroed = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with traffic on the input.
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;
        tick();
        mon_en = 1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // Streaming at full rate.
        out_ready = 1'b1; lat_chk = 1;
        in_valid = 1'b1; in_data = 32'h100; tick();
        in_data = 32'h104; tick();
        in_data = 32'h108; tick();
        in_valid = 1'b0;
        chk("stream_occ_peak", occupancy, 3);
        chk("stream_first", out_data, 32'h100);
        chk("stream_bubble_fill", bubble_cnt, 3);
        tick(); chk("stream_second", out_data, 32'h104);
        tick(); chk("stream_third", out_data, 32'h108);
        tick();
        chk("stream_empty", out_valid, 0);
        chk("stream_bubble_end", bubble_cnt, 3);
        chk("stream_stall_end", stall_cnt, 0);
        lat_chk = 0;

        // Backpressure: fill, hold, then release with simultaneous accept and emit.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'd1; tick();
        in_data = 32'd2; tick();
        in_data = 32'd3; tick();
        in_data = 32'd4;
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_occ", occupancy, 3);
        chk("bp_head", out_data, 32'd1);
        chk("bp_stall_start", stall_cnt, 0);
        tick(); tick();
        chk("bp_stall_held", stall_cnt, 2);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_next_head", out_data, 32'd2);
        chk("bp_occ_steady", occupancy, 3);
        chk("bp_stall_after", stall_cnt, 2);
        in_data = 32'd5; tick();
        drain("bp_drain");

        // Freeze on a full chain.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h40; tick();
        in_data = 32'h41; tick();
        in_data = 32'h42; tick();
        freeze = 1'b1; out_ready = 1'b1; in_data = 32'h99;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("frz_in_ready", in_ready, 0);
            chk("frz_out_data", out_data, 32'h40);
            chk("frz_occ", occupancy, 3);
            tick();
        end
        freeze = 1'b0; in_valid = 1'b0;
        chk("frz_stall", stall_cnt, 4);
        chk("frz_bubble", bubble_cnt, 0);
        drain("frz_drain");

        // Flush wins over freeze and a pending input word.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h51; tick();
        in_data = 32'h52; tick();
        in_valid = 1'b0; tick();
        tick();
        chk("fl_stall_before", stall_cnt, 1);
        flush = 1'b1; freeze = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid_visible", out_valid, 1);
        tick();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fl_occ", occupancy, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_data", out_data, 0);
        chk("fl_stall_kept", stall_cnt, 1);
        chk("fl_bubble_kept", bubble_cnt, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("fl_bubble_after", bubble_cnt, 5);

        // Counter saturation.
        do_reset();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("sat_bubble_15", bubble_cnt, 15);
        for (int k = 0; k < 5; k++) tick();
        chk("sat_bubble_hold", bubble_cnt, 15);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat_bubble_rst", bubble_cnt, 0);

        // Random traffic with occasional freeze, flush and reset.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            freeze    = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
